// File: rtl/axi2ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi2ahb_pkg
// Description : Shared constants and state encodings for the AXI4-Lite to
//               AHB command generator (AHB transfer codes, AXI response
//               codes, read-timeout filler data, FSM state types).
// Revision    : 1.0 - initial release
// ============================================================================
package axi2ahb_pkg;

    localparam logic [1:0]  HTRANS_IDLE     = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ   = 2'b10;
    localparam logic [2:0]  HBURST_SINGLE   = 3'b000;
    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
    localparam logic [31:0] RD_TIMEOUT_DATA = 32'hDEAD_BEEF;

    // Top-level transaction FSM. ST_CMD covers the SETUP/PULSE/HOLD
    // sequence, which is run by the command-issue sub-module.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_W_ACC  = 3'd1,
        ST_R_ACC  = 3'd2,
        ST_CMD    = 3'd3,
        ST_B_RESP = 3'd4,
        ST_R_WAIT = 3'd5,
        ST_R_RESP = 3'd6
    } gen_state_e;

    // Command-issue sequencer FSM.
    typedef enum logic [1:0] {
        IS_IDLE  = 2'd0,
        IS_SETUP = 2'd1,
        IS_PULSE = 2'd2,
        IS_HOLD  = 2'd3
    } issue_state_e;

endpackage : axi2ahb_pkg
`default_nettype wire

// File: rtl/axi2ahb_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module      : axi2ahb_cmd_issue
// Description : SETUP/PULSE/HOLD sequencer that presents one AHB single
//               transfer command to the pipe and strobes AHB_START once,
//               waiting in SETUP while the pipe command FIFOs are full.
// Ports       : clk, rst_n        - clock, synchronous active-low reset
//               i_req            - start a command (sampled in IS_IDLE)
//               o_ack            - high during HOLD, command complete
//               i_addr/i_data/i_type - command fields to latch
//               i_fifo_full      - pipe back-pressure
//               o_ar_send, o_data_send, o_tran_type, o_tran_status,
//               o_burst_type, o_ahb_start - registered command outputs
// Revision    : 1.0 - initial release
// ============================================================================
module axi2ahb_cmd_issue
    import axi2ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    output logic              o_ack,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_type,
    input  logic              i_fifo_full,
    output logic [ADDR_W-1:0] o_ar_send,
    output logic [DATA_W-1:0] o_data_send,
    output logic              o_tran_type,
    output logic [1:0]        o_tran_status,
    output logic [2:0]        o_burst_type,
    output logic              o_ahb_start
);

    issue_state_e      state_q,       state_d;
    logic [ADDR_W-1:0] ar_send_q,     ar_send_d;
    logic [DATA_W-1:0] data_send_q,   data_send_d;
    logic              tran_type_q,   tran_type_d;
    logic [1:0]        tran_status_q, tran_status_d;
    logic [2:0]        burst_type_q,  burst_type_d;
    logic              ahb_start_q,   ahb_start_d;

    always_comb begin
        state_d       = state_q;
        ar_send_d     = ar_send_q;
        data_send_d   = data_send_q;
        tran_type_d   = tran_type_q;
        tran_status_d = tran_status_q;
        burst_type_d  = burst_type_q;
        ahb_start_d   = 1'b0;
        case (state_q)
            IS_IDLE: begin
                // Command fields are loaded on entry to SETUP so they are
                // already stable a full cycle before the AHB_START edge.
                if (i_req) begin
                    state_d       = IS_SETUP;
                    ar_send_d     = i_addr;
                    data_send_d   = i_data;
                    tran_type_d   = i_type;
                    tran_status_d = HTRANS_NONSEQ;
                    burst_type_d  = HBURST_SINGLE;
                end
            end
            IS_SETUP: begin
                if (!i_fifo_full) begin
                    state_d     = IS_PULSE;
                    ahb_start_d = 1'b1;
                end
            end
            IS_PULSE: begin
                state_d = IS_HOLD;
            end
            IS_HOLD: begin
                state_d       = IS_IDLE;
                tran_status_d = HTRANS_IDLE;
            end
            default: begin
                state_d = IS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IS_IDLE;
            ar_send_q     <= '0;
            data_send_q   <= '0;
            tran_type_q   <= 1'b0;
            tran_status_q <= 2'b00;
            burst_type_q  <= 3'b000;
            ahb_start_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ar_send_q     <= ar_send_d;
            data_send_q   <= data_send_d;
            tran_type_q   <= tran_type_d;
            tran_status_q <= tran_status_d;
            burst_type_q  <= burst_type_d;
            ahb_start_q   <= ahb_start_d;
        end
    end

    assign o_ack         = (state_q == IS_HOLD);
    assign o_ar_send     = ar_send_q;
    assign o_data_send   = data_send_q;
    assign o_tran_type   = tran_type_q;
    assign o_tran_status = tran_status_q;
    assign o_burst_type  = burst_type_q;
    assign o_ahb_start   = ahb_start_q;

endmodule : axi2ahb_cmd_issue
`default_nettype wire

// File: rtl/axi_lite_ahb_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_ahb_cmd_gen
// Description : AXI4-Lite slave front end of the AHB master pipe. Converts
//               single-beat AXI writes/reads into AHB single-transfer
//               commands and returns read data from the pipe receive FIFO.
//               One AXI transaction is in flight at a time.
// Ports       : M_HCLK / M_nREST          - clock, synchronous active-low reset
//               S_AXI_AW*/W*/B*/AR*/R*    - AXI4-Lite slave channels
//               AR_SEND, DATA_SEND, TRAN_TYPE, TRAN_STATUS, BURST_TYPE,
//               AHB_START                 - command to the AHB pipe
//               FIFO_FULL                 - pipe command FIFO back-pressure
//               RECV_FIFO_EMPTY, DATA_RECV, RECV_RD - receive FIFO access
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_ahb_cmd_gen
    import axi2ahb_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_RD_TIMEOUT       = 256
) (
    input  logic                          M_HCLK,
    input  logic                          M_nREST,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [C_S_AXI_ADDR_WIDTH-1:0] AR_SEND,
    output logic [C_S_AXI_DATA_WIDTH-1:0] DATA_SEND,
    output logic                          TRAN_TYPE,
    output logic [1:0]                    TRAN_STATUS,
    output logic [2:0]                    BURST_TYPE,
    output logic                          AHB_START,
    input  logic                          FIFO_FULL,
    input  logic                          RECV_FIFO_EMPTY,
    output logic                          RECV_RD,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] DATA_RECV
);

    localparam int unsigned c_cnt_w = (C_RD_TIMEOUT > 2) ? $clog2(C_RD_TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(C_RD_TIMEOUT - 1);
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] c_addr_lsb_mask =
        {{(C_S_AXI_ADDR_WIDTH-2){1'b0}}, 2'b11};

    gen_state_e                    state_q,   state_d;
    logic                          rr_last_q, rr_last_d;   // 1 = write granted last
    logic [c_cnt_w-1:0]            cnt_q,     cnt_d;
    logic                          awready_q, awready_d;
    logic                          wready_q,  wready_d;
    logic                          arready_q, arready_d;
    logic                          bvalid_q,  bvalid_d;
    logic [1:0]                    bresp_q,   bresp_d;
    logic                          rvalid_q,  rvalid_d;
    logic [1:0]                    rresp_q,   rresp_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic                          recv_rd_q, recv_rd_d;

    logic                          w_wr_pend;
    logic                          w_rd_pend;
    logic                          w_strb_ok;
    logic                          w_issue_req;
    logic                          w_issue_ack;
    logic [C_S_AXI_ADDR_WIDTH-1:0] w_issue_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_issue_data;
    logic                          w_issue_type;

    assign w_wr_pend = S_AXI_AWVALID & S_AXI_WVALID;
    assign w_rd_pend = S_AXI_ARVALID;
    assign w_strb_ok = (S_AXI_WSTRB == 4'hF);

    // The accept cycle is also the cycle the command is handed to the
    // sequencer: AXI holds address/data stable until the handshake edge,
    // so the sequencer can latch them straight from the bus.
    assign w_issue_req  = ((state_q == ST_W_ACC) && w_strb_ok) || (state_q == ST_R_ACC);
    assign w_issue_type = (state_q == ST_W_ACC);
    assign w_issue_addr = w_issue_type ? (S_AXI_AWADDR & ~c_addr_lsb_mask)
                                       : (S_AXI_ARADDR & ~c_addr_lsb_mask);
    assign w_issue_data = w_issue_type ? S_AXI_WDATA : '0;

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        cnt_d     = cnt_q;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        arready_d = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        recv_rd_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Round-robin only matters when both directions are pending.
                if (w_wr_pend && (!w_rd_pend || !rr_last_q)) begin
                    state_d   = ST_W_ACC;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    rr_last_d = 1'b1;
                end else if (w_rd_pend) begin
                    state_d   = ST_R_ACC;
                    arready_d = 1'b1;
                    rr_last_d = 1'b0;
                end
            end
            ST_W_ACC: begin
                if (w_strb_ok) begin
                    state_d = ST_CMD;
                end else begin
                    // Partial writes are not supported by the pipe.
                    state_d  = ST_B_RESP;
                    bvalid_d = 1'b1;
                    bresp_d  = AXI_RESP_SLVERR;
                end
            end
            ST_R_ACC: begin
                state_d = ST_CMD;
            end
            ST_CMD: begin
                if (w_issue_ack) begin
                    if (rr_last_q) begin
                        state_d  = ST_B_RESP;
                        bvalid_d = 1'b1;
                        bresp_d  = AXI_RESP_OKAY;
                    end else begin
                        state_d = ST_R_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            ST_B_RESP: begin
                if (S_AXI_BREADY) begin
                    state_d  = ST_IDLE;
                    bvalid_d = 1'b0;
                end
            end
            ST_R_WAIT: begin
                // Data present on the timeout cycle takes priority.
                if (!RECV_FIFO_EMPTY) begin
                    state_d   = ST_R_RESP;
                    rvalid_d  = 1'b1;
                    rdata_d   = DATA_RECV;
                    rresp_d   = AXI_RESP_OKAY;
                    recv_rd_d = 1'b1;
                end else if (cnt_q == c_timeout_last) begin
                    state_d  = ST_R_RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = RD_TIMEOUT_DATA;
                    rresp_d  = AXI_RESP_SLVERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_R_RESP: begin
                if (S_AXI_RREADY) begin
                    state_d  = ST_IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge M_HCLK) begin
        if (!M_nREST) begin
            state_q   <= ST_IDLE;
            rr_last_q <= 1'b0;
            cnt_q     <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            recv_rd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            cnt_q     <= cnt_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            recv_rd_q <= recv_rd_d;
        end
    end

    axi2ahb_cmd_issue #(
        .ADDR_W (C_S_AXI_ADDR_WIDTH),
        .DATA_W (C_S_AXI_DATA_WIDTH)
    ) u_cmd_issue (
        .clk           (M_HCLK),
        .rst_n         (M_nREST),
        .i_req         (w_issue_req),
        .o_ack         (w_issue_ack),
        .i_addr        (w_issue_addr),
        .i_data        (w_issue_data),
        .i_type        (w_issue_type),
        .i_fifo_full   (FIFO_FULL),
        .o_ar_send     (AR_SEND),
        .o_data_send   (DATA_SEND),
        .o_tran_type   (TRAN_TYPE),
        .o_tran_status (TRAN_STATUS),
        .o_burst_type  (BURST_TYPE),
        .o_ahb_start   (AHB_START)
    );

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign RECV_RD       = recv_rd_q;

endmodule : axi_lite_ahb_cmd_gen
`default_nettype wire

// File: tb/tb_axi_lite_ahb_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_ahb_cmd_gen
// Description : Scoreboard bench for axi_lite_ahb_cmd_gen. Directed AXI
//               transactions push expected AHB commands and B/R responses
//               into queues; a monitor pops and compares them when the DUT
//               presents AHB_START, B or R handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_ahb_cmd_gen;

    localparam int C_RD_TIMEOUT = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [31:0] S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] AR_SEND;
    logic [31:0] DATA_SEND;
    logic        TRAN_TYPE;
    logic [1:0]  TRAN_STATUS;
    logic [2:0]  BURST_TYPE;
    logic        AHB_START;
    logic        FIFO_FULL;
    logic        RECV_FIFO_EMPTY;
    logic        RECV_RD;
    logic [31:0] DATA_RECV;

    always #5 clk = ~clk;

    axi_lite_ahb_cmd_gen #(
        .C_S_AXI_ADDR_WIDTH (32),
        .C_S_AXI_DATA_WIDTH (32),
        .C_RD_TIMEOUT       (C_RD_TIMEOUT)
    ) dut (
        .M_HCLK          (clk),
        .M_nREST         (rst_n),
        .S_AXI_AWADDR    (S_AXI_AWADDR),
        .S_AXI_AWVALID   (S_AXI_AWVALID),
        .S_AXI_AWREADY   (S_AXI_AWREADY),
        .S_AXI_WDATA     (S_AXI_WDATA),
        .S_AXI_WSTRB     (S_AXI_WSTRB),
        .S_AXI_WVALID    (S_AXI_WVALID),
        .S_AXI_WREADY    (S_AXI_WREADY),
        .S_AXI_BRESP     (S_AXI_BRESP),
        .S_AXI_BVALID    (S_AXI_BVALID),
        .S_AXI_BREADY    (S_AXI_BREADY),
        .S_AXI_ARADDR    (S_AXI_ARADDR),
        .S_AXI_ARVALID   (S_AXI_ARVALID),
        .S_AXI_ARREADY   (S_AXI_ARREADY),
        .S_AXI_RDATA     (S_AXI_RDATA),
        .S_AXI_RRESP     (S_AXI_RRESP),
        .S_AXI_RVALID    (S_AXI_RVALID),
        .S_AXI_RREADY    (S_AXI_RREADY),
        .AR_SEND         (AR_SEND),
        .DATA_SEND       (DATA_SEND),
        .TRAN_TYPE       (TRAN_TYPE),
        .TRAN_STATUS     (TRAN_STATUS),
        .BURST_TYPE      (BURST_TYPE),
        .AHB_START       (AHB_START),
        .FIFO_FULL       (FIFO_FULL),
        .RECV_FIFO_EMPTY (RECV_FIFO_EMPTY),
        .RECV_RD         (RECV_RD),
        .DATA_RECV       (DATA_RECV)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        typ;
    } cmd_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    cmd_t        exp_cmd[$];
    logic [1:0]  exp_b[$];
    rsp_t        exp_r[$];
    logic [31:0] recv_q[$];

    int n_tests     = 0;
    int n_fail      = 0;
    int start_cnt   = 0;
    int recv_rd_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected event expected none", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [31:0] a, input logic [31:0] d, input logic t);
        cmd_t c;
        c.addr = a;
        c.data = d;
        c.typ  = t;
        exp_cmd.push_back(c);
    endtask

    task automatic push_r(input logic [31:0] d, input logic [1:0] r);
        rsp_t x;
        x.data = d;
        x.resp = r;
        exp_r.push_back(x);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        bit ok = 0;
        S_AXI_AWADDR  = a;
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        while (!ok && n < 500) begin
            @(negedge clk);
            n++;
            ok = S_AXI_AWREADY && S_AXI_WREADY;
        end
        if (!ok) fail_now("aw_w_accept");
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a);
        int n = 0;
        bit ok = 0;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        while (!ok && n < 500) begin
            @(negedge clk);
            n++;
            ok = S_AXI_ARREADY;
        end
        if (!ok) fail_now("ar_accept");
        tick();
        S_AXI_ARVALID = 1'b0;
    endtask

    // Negedges until AHB_START is seen (0 on timeout).
    task automatic wait_start(output int n);
        int k = 0;
        bit ok = 0;
        while (!ok && k < 100) begin
            @(negedge clk);
            k++;
            ok = AHB_START;
        end
        if (!ok) begin
            fail_now("ahb_start_wait");
            k = 0;
        end
        n = k;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0 || exp_cmd.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) fail_now("response_wait");
        repeat (2) tick();
    endtask

    // Receive FIFO model: head visible while non-empty, popped by RECV_RD.
    initial begin
        forever begin
            @(negedge clk);
            if (RECV_RD && recv_q.size() > 0) void'(recv_q.pop_front());
            RECV_FIFO_EMPTY = (recv_q.size() == 0);
            DATA_RECV       = (recv_q.size() == 0) ? 32'h0 : recv_q[0];
        end
    end

    // Monitor / scoreboard.
    logic       prev_start  = 1'b0;
    logic       prev_bvalid = 1'b0;
    logic       prev_bready = 1'b0;
    logic [1:0] prev_bresp  = 2'b00;
    logic       prev_rvalid = 1'b0;
    logic       prev_rready = 1'b0;
    logic [1:0] prev_rresp  = 2'b00;
    logic [31:0] prev_rdata = 32'h0;

    initial begin
        cmd_t c;
        rsp_t r;
        logic [1:0] b;
        forever begin
            @(negedge clk);
            if (AHB_START) begin
                start_cnt++;
                if (prev_start) fail_now("ahb_start_width");
                if (exp_cmd.size() == 0) begin
                    fail_now("unexpected_ahb_start");
                end else begin
                    c = exp_cmd.pop_front();
                    check("ahb_cmd", {AR_SEND, DATA_SEND, TRAN_TYPE, TRAN_STATUS, BURST_TYPE},
                          {c.addr, c.data, c.typ, 2'b10, 3'b000});
                end
            end
            if (RECV_RD) recv_rd_cnt++;
            if (prev_bvalid && !prev_bready)
                check("b_hold", {S_AXI_BVALID, S_AXI_BRESP}, {1'b1, prev_bresp});
            if (prev_rvalid && !prev_rready)
                check("r_hold", {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}, {1'b1, prev_rresp, prev_rdata});
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                if (exp_b.size() == 0) begin
                    fail_now("unexpected_b");
                end else begin
                    b = exp_b.pop_front();
                    check("bresp", S_AXI_BRESP, b);
                end
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (exp_r.size() == 0) begin
                    fail_now("unexpected_r");
                end else begin
                    r = exp_r.pop_front();
                    check("rdata_rresp", {S_AXI_RDATA, S_AXI_RRESP}, {r.data, r.resp});
                end
            end
            prev_start  = AHB_START;
            prev_bvalid = S_AXI_BVALID;
            prev_bready = S_AXI_BREADY;
            prev_bresp  = S_AXI_BRESP;
            prev_rvalid = S_AXI_RVALID;
            prev_rready = S_AXI_RREADY;
            prev_rresp  = S_AXI_RRESP;
            prev_rdata  = S_AXI_RDATA;
        end
    end

    task automatic check_all_zero(input string name);
        check(name, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY,
                     S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA, AR_SEND, DATA_SEND, TRAN_TYPE,
                     TRAN_STATUS, BURST_TYPE, AHB_START, RECV_RD}, 128'h0);
    endtask

    initial begin
        int n;
        int s0;
        int rr0;
        rst_n         = 1'b0;
        S_AXI_AWADDR  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = 4'h0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b1;
        S_AXI_ARADDR  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        FIFO_FULL     = 1'b0;
        RECV_FIFO_EMPTY = 1'b1;
        DATA_RECV     = '0;

        repeat (2) tick();
        @(negedge clk);
        check_all_zero("reset_state");
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Write, address LSBs cleared, start 2 cycles after accept, B 2 after start.
        push_cmd(32'h0000_1004, 32'h1234_5678, 1'b1);
        exp_b.push_back(2'b00);
        axi_write(32'h0000_1006, 32'h1234_5678, 4'hF);
        wait_start(n);
        check("wr_start_latency", n, 2);
        n = 0;
        do begin @(negedge clk); n++; end while (!S_AXI_BVALID && n < 50);
        check("wr_bvalid_latency", n, 2);
        wait_done();

        // Read with receive data arriving 5 cycles after the pulse.
        rr0 = recv_rd_cnt;
        push_cmd(32'h0000_0040, 32'h0, 1'b0);
        push_r(32'hCAFE_0001, 2'b00);
        axi_read(32'h0000_0040);
        wait_start(n);
        repeat (4) @(negedge clk);
        tick();
        recv_q.push_back(32'hCAFE_0001);
        n = 0;
        do begin @(negedge clk); n++; end while (!S_AXI_RVALID && n < 50);
        check("rd_rvalid_latency", n, 2);
        wait_done();
        check("recv_rd_pulses", recv_rd_cnt - rr0, 1);

        // Partial strobe write: SLVERR, no AHB command.
        s0 = start_cnt;
        exp_b.push_back(2'b10);
        axi_write(32'h0000_2000, 32'hFFFF_0000, 4'h3);
        wait_done();
        check("strb_no_start", start_cnt - s0, 0);

        // Read timeout.
        push_cmd(32'h0000_0100, 32'h0, 1'b0);
        push_r(32'hDEAD_BEEF, 2'b10);
        axi_read(32'h0000_0103);
        wait_start(n);
        n = 0;
        do begin @(negedge clk); n++; end while (!S_AXI_RVALID && n < 1000);
        check("rd_timeout_latency", n, C_RD_TIMEOUT + 2);
        wait_done();

        // FIFO_FULL back-pressure for 10 cycles.
        s0 = start_cnt;
        FIFO_FULL = 1'b1;
        push_cmd(32'h0000_3008, 32'h0BAD_F00D, 1'b1);
        exp_b.push_back(2'b00);
        axi_write(32'h0000_3008, 32'h0BAD_F00D, 4'hF);
        repeat (10) tick();
        check("full_no_start", start_cnt - s0, 0);
        FIFO_FULL = 1'b0;
        wait_done();
        check("full_one_start", start_cnt - s0, 1);

        // Simultaneous write and read, twice; last grant was a write.
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        recv_q.push_back(32'hBEEF_0001);
        recv_q.push_back(32'hBEEF_0002);
        push_cmd(32'h0000_0080, 32'h0, 1'b0);
        push_cmd(32'h0000_2000, 32'hA5A5_A5A5, 1'b1);
        push_r(32'hBEEF_0001, 2'b00);
        exp_b.push_back(2'b00);
        fork
            axi_write(32'h0000_2000, 32'hA5A5_A5A5, 4'hF);
            axi_read(32'h0000_0080);
        join_none
        n = 0;
        do begin @(negedge clk); n++; end while (!S_AXI_RVALID && n < 100);
        if (n >= 100) fail_now("rr1_rvalid_wait");
        repeat (4) tick();
        S_AXI_RREADY = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!S_AXI_BVALID && n < 100);
        if (n >= 100) fail_now("rr1_bvalid_wait");
        repeat (4) tick();
        S_AXI_BREADY = 1'b1;
        wait_done();

        push_cmd(32'h0000_0084, 32'h0, 1'b0);
        push_cmd(32'h0000_2004, 32'h5A5A_5A5A, 1'b1);
        push_r(32'hBEEF_0002, 2'b00);
        exp_b.push_back(2'b00);
        fork
            axi_write(32'h0000_2004, 32'h5A5A_5A5A, 4'hF);
            axi_read(32'h0000_0084);
        join
        wait_done();

        // Reset during the PULSE cycle.
        push_cmd(32'h0000_4000, 32'h1111_2222, 1'b1);
        exp_b.push_back(2'b00);
        axi_write(32'h0000_4000, 32'h1111_2222, 4'hF);
        n = 0;
        do begin tick(); n++; end while (!AHB_START && n < 50);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset_mid_pulse");
        exp_b.delete();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("no_resp_after_reset", {S_AXI_BVALID, AHB_START}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_axi_lite_ahb_cmd_gen
`default_nettype wire
